// File: rtl/clint_mtimer.sv
// CLINT-style machine timer: 64-bit mtime, per-hart mtimecmp and msip,
// exposed through an AXI4-Lite slave with independent read and write paths.
module clint_mtimer #(
    parameter int unsigned HARTS    = 1,
    parameter int unsigned PRESCALE = 1,
    parameter logic [31:0] BASE     = 32'h0200_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      araddr,
    input  logic             arvalid,
    output logic             arready,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rvalid,
    input  logic             rready,
    input  logic [31:0]      awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wvalid,
    output logic             wready,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    output logic [HARTS-1:0] msip_o,
    output logic [HARTS-1:0] mtip_o
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [13:0] CMP_W   = 14'h1000;
    localparam logic [13:0] MTL_W   = 14'h2FFE;
    localparam logic [13:0] MTH_W   = 14'h2FFF;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  DECERR  = 2'b11;

    typedef enum logic [2:0] {R_NONE, R_MSIP, R_CMPL, R_CMPH, R_MTL, R_MTH} reg_e;
    typedef struct packed {
        reg_e       kind;
        logic [2:0] hart;
    } dec_t;

    // Only the low 16 offset bits and the word index matter for decode.
    function automatic dec_t decode(input logic [15:0] addr);
        logic [13:0] w;
        dec_t        d;
        w      = 14'((addr - BASE[15:0]) >> 2);
        d.kind = R_NONE;
        d.hart = 3'd0;
        if (w == MTL_W) begin
            d.kind = R_MTL;
        end else if (w == MTH_W) begin
            d.kind = R_MTH;
        end else if (w < 14'(HARTS)) begin
            d.kind = R_MSIP;
            d.hart = w[2:0];
        end else if (w >= CMP_W && w < CMP_W + 14'(2 * HARTS)) begin
            d.kind = w[0] ? R_CMPH : R_CMPL;
            d.hart = w[3:1];
        end
        return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    logic [15:0]       pre_q, pre_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [7:0]        msip_q, msip_d;
    logic [7:0][63:0]  cmp_q, cmp_d;
    logic [HARTS-1:0]  mtip_q, mtip_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    dec_t              rd_dec, wr_dec;
    logic              ar_hs, wr_hs, tick;
    logic [31:0]       rd_val;
    logic              unused_addr_hi;

    assign unused_addr_hi = &{1'b0, araddr[31:16], awaddr[31:16]};

    assign arready = ~rvalid_q;
    // Both write channels are taken in the same cycle, never one alone.
    assign awready = rst & awvalid & wvalid & ~bvalid_q;
    assign wready  = awready;

    always_comb begin
        rd_dec = decode(araddr[15:0]);
        wr_dec = decode(awaddr[15:0]);
        ar_hs  = arvalid & ~rvalid_q;
        wr_hs  = awready;
        tick   = (pre_q == PRE_MAX);

        pre_d   = tick ? 16'd0 : pre_q + 16'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        msip_d  = msip_q;
        cmp_d   = cmp_q;

        // A register write overrides the increment; the untouched mtime half
        // keeps its pre-increment value.
        if (wr_hs) begin
            case (wr_dec.kind)
                R_MSIP: if (wstrb[0]) msip_d[wr_dec.hart] = wdata[0];
                R_CMPL: cmp_d[wr_dec.hart][31:0]  = merge(cmp_q[wr_dec.hart][31:0], wdata, wstrb);
                R_CMPH: cmp_d[wr_dec.hart][63:32] = merge(cmp_q[wr_dec.hart][63:32], wdata, wstrb);
                R_MTL: begin
                    mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata, wstrb)};
                    pre_d   = 16'd0;
                end
                R_MTH: begin
                    mtime_d = {merge(mtime_q[63:32], wdata, wstrb), mtime_q[31:0]};
                    pre_d   = 16'd0;
                end
                default: ;
            endcase
        end

        case (rd_dec.kind)
            R_MSIP:  rd_val = {31'd0, msip_q[rd_dec.hart]};
            R_CMPL:  rd_val = cmp_q[rd_dec.hart][31:0];
            R_CMPH:  rd_val = cmp_q[rd_dec.hart][63:32];
            R_MTL:   rd_val = mtime_q[31:0];
            R_MTH:   rd_val = mtime_q[63:32];
            default: rd_val = 32'd0;
        endcase

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = (rd_dec.kind == R_NONE) ? DECERR : OKAY;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_dec.kind == R_NONE) ? DECERR : OKAY;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        mtip_d = '0;
        for (int h = 0; h < int'(HARTS); h++) begin
            mtip_d[h] = (mtime_q >= cmp_q[h]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            mtime_q  <= '0;
            msip_q   <= '0;
            cmp_q    <= '1;
            mtip_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            pre_q    <= pre_d;
            mtime_q  <= mtime_d;
            msip_q   <= msip_d;
            cmp_q    <= cmp_d;
            mtip_q   <= mtip_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign msip_o = msip_q[HARTS-1:0];
    assign mtip_o = mtip_q;

endmodule

// File: tb/tb_clint_mtimer.sv
// Bench for clint_mtimer: scenario tasks checked against an address-map level
// model where mtime is derived from elapsed clock edges.
module tb_clint_mtimer;
    localparam int          HARTS    = 2;
    localparam int          PRESCALE = 1;
    localparam logic [31:0] BASE     = 32'h0200_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      araddr, rdata, awaddr, wdata;
    logic             arvalid, arready, rvalid, rready;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]       rresp, bresp;
    logic [3:0]       wstrb;
    logic [HARTS-1:0] msip_o, mtip_o;

    clint_mtimer #(.HARTS(HARTS), .PRESCALE(PRESCALE), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .msip_o(msip_o), .mtip_o(mtip_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: mtime after edge c is m_base + (c - m_bcyc) / PRESCALE.
    logic [63:0]      m_base;
    longint           m_bcyc;
    logic [63:0]      m_cmp [HARTS];
    logic [HARTS-1:0] m_msip;
    logic [HARTS-1:0] acc_mtip;

    function automatic logic [63:0] m_mtime(input longint c);
        return m_base + 64'((c - m_bcyc) / PRESCALE);
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_base = 64'd0;
        m_msip = '0;
        for (int h = 0; h < HARTS; h++) m_cmp[h] = '1;
    endtask

    task automatic model_read(input logic [15:0] off, input longint c,
                              output logic [31:0] d, output logic [1:0] r);
        int o;
        logic [63:0] t;
        o = int'(off);
        d = 32'd0;
        r = 2'b00;
        t = m_mtime(c - 1);
        if (o == 'hBFF8) d = t[31:0];
        else if (o == 'hBFFC) d = t[63:32];
        else if (o < 4 * HARTS) d = {31'd0, m_msip[o/4]};
        else if (o >= 'h4000 && o < 'h4000 + 8 * HARTS) begin
            t = m_cmp[(o - 'h4000) / 8];
            d = (o % 8 == 0) ? t[31:0] : t[63:32];
        end else r = 2'b11;
    endtask

    task automatic model_write(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s,
                               input longint c, output logic [1:0] r);
        int o;
        logic [63:0] t;
        o = int'(off);
        r = 2'b00;
        if (o == 'hBFF8 || o == 'hBFFC) begin
            t = m_mtime(c - 1);
            if (o == 'hBFF8) t[31:0] = bytes_merge(t[31:0], d, s);
            else             t[63:32] = bytes_merge(t[63:32], d, s);
            m_base = t;
            m_bcyc = c;
        end else if (o < 4 * HARTS) begin
            if (s[0]) m_msip[o/4] = d[0];
        end else if (o >= 'h4000 && o < 'h4000 + 8 * HARTS) begin
            t = m_cmp[(o - 'h4000) / 8];
            if (o % 8 == 0) t[31:0] = bytes_merge(t[31:0], d, s);
            else            t[63:32] = bytes_merge(t[63:32], d, s);
            m_cmp[(o - 'h4000) / 8] = t;
        end else r = 2'b11;
    endtask

    task automatic axi_read(input logic [15:0] off, output logic [31:0] d,
                            output logic [1:0] r, output longint c);
        int n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        araddr = BASE + 32'(off); arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0; c = cyc;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_rise: got %b want 1", rvalid); end
        d = rdata; r = rresp;
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    endtask

    task automatic axi_write(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r, output logic [1:0] er);
        int n = 0;
        while (bvalid && n < 20) begin @(posedge clk); #1; n++; end
        awaddr = BASE + 32'(off); wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        acc_mtip = mtip_o;
        model_write(off, d, s, cyc, er);
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_rise: got %b want 1", bvalid); end
        r = bresp;
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b0; arvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        araddr = BASE; awaddr = BASE; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {arready, awready, wready, rvalid, bvalid, rresp, bresp, msip_o, mtip_o, 1'b0};
        checks++;
        if (got !== 14'b1000_0000_0000_00)
            begin errors++; $display("FAIL reset_outputs: got %b want 10000000000000", got); end
        checks++;
        if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        awvalid = 1'b0; wvalid = 1'b0;
        model_reset();
        rst = 1'b1;
        m_bcyc = cyc;
    endtask

    task automatic test_mtime_idle();
        logic [31:0] d, ed; logic [1:0] r, er; longint c;
        repeat (100) begin @(posedge clk); #1; end
        axi_read(16'hBFF8, d, r, c);
        model_read(16'hBFF8, c, ed, er);
        checks++;
        if (d !== ed || r !== 2'b00 || d < 97 || d > 103)
            begin errors++; $display("FAIL mtime_idle: got %0d/%b want %0d/00", d, r, ed); end
        axi_read(16'hBFFC, d, r, c);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mtime_hi_idle: got %h want 0", d); end
    endtask

    task automatic test_mtip();
        logic [1:0] r, er;
        logic exp0;
        axi_write(16'hBFF8, 32'd0, 4'hF, r, er);
        axi_write(16'h4000, 32'd20, 4'hF, r, er);
        axi_write(16'h4004, 32'd0, 4'hF, r, er);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            exp0 = (m_mtime(cyc - 1) >= m_cmp[0]);
            checks++;
            if (mtip_o !== {1'b0, exp0})
                begin errors++; $display("FAIL mtip_rise: cyc %0d got %b want %b", i, mtip_o, {1'b0, exp0}); end
        end
        axi_write(16'h4004, 32'd1, 4'hF, r, er);
        checks++;
        if (acc_mtip[0] !== 1'b1 || mtip_o[0] !== 1'b0)
            begin errors++; $display("FAIL mtip_fall: got %b,%b want 1,0", acc_mtip[0], mtip_o[0]); end
    endtask

    task automatic test_wrap();
        logic [31:0] d, ed; logic [1:0] r, er; longint c;
        logic exp0;
        axi_write(16'h4000, 32'hFFFF_FFFF, 4'hF, r, er);
        axi_write(16'h4004, 32'hFFFF_FFFF, 4'hF, r, er);
        axi_write(16'hBFFC, 32'hFFFF_FFFF, 4'hF, r, er);
        axi_write(16'hBFF8, 32'hFFFF_FFFF, 4'hF, r, er);
        checks++;
        if (acc_mtip[0] !== 1'b0) begin errors++; $display("FAIL wrap_pre_mtip: got %b want 0", acc_mtip[0]); end
        exp0 = (m_mtime(cyc - 1) >= m_cmp[0]);
        checks++;
        if (mtip_o[0] !== exp0) begin errors++; $display("FAIL wrap_peak_mtip: got %b want %b", mtip_o[0], exp0); end
        axi_read(16'hBFF8, d, r, c);
        model_read(16'hBFF8, c, ed, er);
        checks++;
        if (d !== ed || d !== 32'd0) begin errors++; $display("FAIL wrap_lo: got %h want %h", d, ed); end
        axi_read(16'hBFFC, d, r, c);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL wrap_hi: got %h want 0", d); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mtip_o !== 2'b00) begin errors++; $display("FAIL wrap_mtip_after: got %b want 00", mtip_o); end
        end
    endtask

    task automatic test_msip();
        logic [31:0] d; logic [1:0] r, er; longint c;
        axi_write(16'h0000, 32'hFFFF_FFFF, 4'b0001, r, er);
        checks++;
        if (msip_o !== m_msip || msip_o !== 2'b01) begin errors++; $display("FAIL msip_set: got %b want 01", msip_o); end
        axi_read(16'h0000, d, r, c);
        checks++;
        if (d !== 32'd1 || r !== 2'b00) begin errors++; $display("FAIL msip_read: got %h/%b want 1/00", d, r); end
        axi_write(16'h0000, 32'd0, 4'b0000, r, er);
        checks++;
        if (msip_o !== 2'b01) begin errors++; $display("FAIL msip_nostrb: got %b want 01", msip_o); end
        axi_write(16'h0000, 32'hFFFF_FFFE, 4'b1110, r, er);
        checks++;
        if (msip_o !== 2'b01) begin errors++; $display("FAIL msip_upper_strb: got %b want 01", msip_o); end
        axi_write(16'h0004, 32'd1, 4'b0001, r, er);
        axi_write(16'h0000, 32'd0, 4'b0001, r, er);
        checks++;
        if (msip_o !== m_msip) begin errors++; $display("FAIL msip_h1: got %b want %b", msip_o, m_msip); end
    endtask

    task automatic test_decerr();
        logic [31:0] d, ed; logic [1:0] r, er; longint c;
        logic [HARTS-1:0] ms;
        axi_read(16'h0008, d, r, c);
        checks++;
        if (r !== 2'b11 || d !== 32'd0) begin errors++; $display("FAIL decerr_rd_msip2: got %h/%b want 0/11", d, r); end
        axi_read(16'h8000, d, r, c);
        checks++;
        if (r !== 2'b11 || d !== 32'd0) begin errors++; $display("FAIL decerr_rd_hole: got %h/%b want 0/11", d, r); end
        axi_write(16'h4010, $urandom, 4'hF, r, er);
        checks++;
        if (r !== 2'b11 || er !== 2'b11) begin errors++; $display("FAIL decerr_wr_cmp2: got %b want 11", r); end
        ms = msip_o;
        axi_write(16'h0008, 32'hFFFF_FFFF, 4'hF, r, er);
        checks++;
        if (r !== 2'b11 || msip_o !== ms) begin errors++; $display("FAIL decerr_wr_msip2: got %b/%b want 11/%b", r, msip_o, ms); end
        for (int i = 0; i < 4; i++) begin
            axi_read(16'(16'h4000 + 4 * i), d, r, c);
            model_read(16'(16'h4000 + 4 * i), c, ed, er);
            checks++;
            if (d !== ed || r !== er) begin errors++; $display("FAIL decerr_cmp_intact: reg %0d got %h want %h", i, d, ed); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held, ed; logic [1:0] er;
        araddr = BASE + 32'h4008; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        model_read(16'h4008, cyc, ed, er);
        held = rdata;
        checks++;
        if (rvalid !== 1'b1 || held !== ed) begin errors++; $display("FAIL bp_first: got %b/%h want 1/%h", rvalid, held, ed); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0 || rresp !== er)
                begin errors++; $display("FAIL bp_hold: cyc %0d got rv=%b rd=%h ar=%b want 1/%h/0", i, rvalid, rdata, arready, held); end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL bp_release: got rv=%b ar=%b want 0/1", rvalid, arready); end
    endtask

    task automatic test_simul_rw();
        logic [31:0] nd, d, ed; logic [1:0] r, er, ewr; longint c;
        nd = $urandom;
        araddr = BASE + 32'h400C; awaddr = BASE + 32'h400C; wdata = nd; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b0; bready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        model_read(16'h400C, cyc, ed, er);
        model_write(16'h400C, nd, 4'hF, cyc, ewr);
        checks++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== ed)
            begin errors++; $display("FAIL simul_prewrite: got %b%b/%h want 11/%h", rvalid, bvalid, rdata, ed); end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        axi_read(16'h400C, d, r, c);
        checks++;
        if (d !== nd) begin errors++; $display("FAIL simul_postwrite: got %h want %h", d, nd); end
    endtask

    task automatic test_random();
        logic [15:0] offs [12];
        logic [15:0] off;
        logic [31:0] d, ed; logic [1:0] r, er; longint c;
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h1000, 16'hBFF4};
        for (int i = 0; i < 40; i++) begin
            off = offs[$urandom_range(11)];
            if ($urandom_range(1) == 1) begin
                axi_write(off, $urandom, 4'($urandom), r, er);
                checks++;
                if (r !== er || msip_o !== m_msip)
                    begin errors++; $display("FAIL rand_wr @%h: got %b/%b want %b/%b", off, r, msip_o, er, m_msip); end
            end else begin
                axi_read(off, d, r, c);
                model_read(off, c, ed, er);
                checks++;
                if (d !== ed || r !== er)
                    begin errors++; $display("FAIL rand_rd @%h: got %h/%b want %h/%b", off, d, r, ed, er); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed; logic [1:0] r, er; longint c;
        araddr = BASE + 32'hBFF8; arvalid = 1'b1; rready = 1'b0;
        awaddr = BASE; wdata = 32'd1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b1 || msip_o !== 2'b00 || mtip_o !== 2'b00)
            begin errors++; $display("FAIL rst_mid_async: got rv=%b bv=%b ar=%b ms=%b mt=%b", rvalid, bvalid, arready, msip_o, mtip_o); end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        m_bcyc = cyc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 1'b0 || bvalid !== 1'b0)
                begin errors++; $display("FAIL rst_mid_noresp: got rv=%b bv=%b want 0/0", rvalid, bvalid); end
        end
        axi_read(16'hBFF8, d, r, c);
        model_read(16'hBFF8, c, ed, er);
        checks++;
        if (d !== ed) begin errors++; $display("FAIL rst_mid_mtime: got %0d want %0d", d, ed); end
        axi_read(16'h4000, d, r, c);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_cmp: got %h want ffffffff", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mtime_idle();
        test_mtip();
        test_wrap();
        test_msip();
        test_decerr();
        test_backpressure();
        test_simul_rw();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
